// File: rtl/next_pc_unit.sv
// Purpose : next-PC selection for a two-phase (FETCH/EXECUTE) core, with halt and an optional return stack.
// Latency : pc_plus is combinational from pc and the controls captured on the FETCH->EXECUTE edge; the PC loads it on EXECUTE->FETCH.
// Backpressure: none; the unit advances every cycle until halted, and a halt lasts until reset.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   pc                  current program counter
//   branch_taken/offset relative branch request and signed displacement
//   jump, call, ret     absolute jump, subroutine call, subroutine return
//   jump_target         absolute target for jump/call
//   halt                permanent stop request
//   pc_plus             next PC value
//   phase               0 = FETCH, 1 = EXECUTE (also 1 while halted)
//   halted              high in HALT
//   stack_full/empty/err  return-stack status (err is sticky)
//
// Build option: define RETURN_STACK_EN to include the return stack. Without it,
// call behaves as jump, ret as sequential, and the stack flags are tied off.
module next_pc_unit #(
    parameter int STEP        = 1,
    parameter int STACK_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pc,
    input  logic       branch_taken,
    input  logic [7:0] branch_offset,
    input  logic       jump,
    input  logic       call,
    input  logic       ret,
    input  logic [7:0] jump_target,
    input  logic       halt,
    output logic [7:0] pc_plus,
    output logic       phase,
    output logic       halted,
    output logic       stack_full,
    output logic       stack_empty,
    output logic       stack_err
);

    if (STEP < 1 || STEP > 15) begin : g_bad_step
        $error("next_pc_unit: STEP must be 1..15");
    end
    if (STACK_DEPTH < 2 || STACK_DEPTH > 8) begin : g_bad_depth
        $error("next_pc_unit: STACK_DEPTH must be 2..8");
    end

    typedef enum logic [1:0] {FETCH, EXECUTE, HALT} state_t;

    localparam logic [7:0] STEP8 = 8'(STEP);

    state_t     state, state_nxt;

    // Controls latched on the FETCH->EXECUTE edge.
    logic       c_br, c_jmp, c_call, c_ret, c_halt;
    logic [7:0] c_off, c_tgt;

    logic [7:0] seq_pc;
    assign seq_pc = pc + STEP8;   // 8-bit add wraps modulo 256

    // ---------------- state machine ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        phase     = 1'b0;
        halted    = 1'b0;
        case (state)
            FETCH:   state_nxt = EXECUTE;
            EXECUTE: begin
                phase     = 1'b1;
                state_nxt = c_halt ? HALT : FETCH;
            end
            HALT: begin
                phase     = 1'b1;
                halted    = 1'b1;
                state_nxt = HALT;
            end
            default: state_nxt = FETCH;
        endcase
    end

    // ---------------- control capture ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_br   <= 1'b0;
            c_off  <= 8'h00;
            c_jmp  <= 1'b0;
            c_call <= 1'b0;
            c_ret  <= 1'b0;
            c_tgt  <= 8'h00;
            c_halt <= 1'b0;
        end else if (state == FETCH) begin
            c_br   <= branch_taken;
            c_off  <= branch_offset;
            c_jmp  <= jump;
            c_call <= call;
            c_ret  <= ret;
            c_tgt  <= jump_target;
            c_halt <= halt;
        end
    end

`ifdef RETURN_STACK_EN
    // ---------------- return stack ----------------
    localparam int AW  = $clog2(STACK_DEPTH);
    localparam int SPW = $clog2(STACK_DEPTH + 1);   // sp counts 0..STACK_DEPTH

    logic [7:0]     stack_mem [STACK_DEPTH];
    logic [SPW-1:0] sp;
    logic           err_q;
    logic           st_full, st_empty;
    logic           do_push, do_pop;
    logic [7:0]     tos;

    assign st_full  = (sp == SPW'(STACK_DEPTH));
    assign st_empty = (sp == '0);
    // Only consumed when not empty, so the wrapped index at sp == 0 is harmless.
    assign tos      = stack_mem[AW'(sp - 1'b1)];

    // Stack effects happen on the EXECUTE->FETCH edge; halt and ret outrank call.
    assign do_pop   = (state == EXECUTE) && !c_halt && c_ret;
    assign do_push  = (state == EXECUTE) && !c_halt && !c_ret && c_call;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp    <= '0;
            err_q <= 1'b0;
        end else if (do_pop) begin
            if (st_empty) err_q <= 1'b1;
            else          sp    <= sp - 1'b1;
        end else if (do_push) begin
            if (st_full)  err_q <= 1'b1;
            else          sp    <= sp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !st_full) stack_mem[AW'(sp)] <= seq_pc;
    end

    assign stack_full  = st_full;
    assign stack_empty = st_empty;
    assign stack_err   = err_q;
`else
    assign stack_full  = 1'b0;
    assign stack_empty = 1'b1;
    assign stack_err   = 1'b0;
`endif

    // ---------------- next-PC select ----------------
    always_comb begin
        pc_plus = seq_pc;
        case (state)
            EXECUTE: begin
                if (c_halt)
                    pc_plus = pc;
                else if (c_ret) begin
`ifdef RETURN_STACK_EN
                    pc_plus = st_empty ? seq_pc : tos;
`else
                    pc_plus = seq_pc;
`endif
                end
                else if (c_call || c_jmp)
                    pc_plus = c_tgt;
                else if (c_br)
                    pc_plus = pc + c_off;   // two's-complement offset, wraps modulo 256
                else
                    pc_plus = seq_pc;
            end
            HALT:    pc_plus = pc;
            default: pc_plus = seq_pc;
        endcase
    end

endmodule

// File: tb/tb_next_pc_unit.sv
module tb_next_pc_unit;

`ifdef RETURN_STACK_EN
    localparam bit RS = 1'b1;
`else
    localparam bit RS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pc;
    logic       branch_taken;
    logic [7:0] branch_offset;
    logic       jump, call, ret;
    logic [7:0] jump_target;
    logic       halt;
    logic [7:0] pc_plus;
    logic       phase, halted, stack_full, stack_empty, stack_err;

    next_pc_unit #(.STEP(1), .STACK_DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .jump         (jump),
        .call         (call),
        .ret          (ret),
        .jump_target  (jump_target),
        .halt         (halt),
        .pc_plus      (pc_plus),
        .phase        (phase),
        .halted       (halted),
        .stack_full   (stack_full),
        .stack_empty  (stack_empty),
        .stack_err    (stack_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pcp;
        logic       ph, hl, fu, em, er;
        int         id;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Flags expected in the cycle being issued (they change on EXECUTE->FETCH).
    logic cur_f = 1'b0, cur_e = 1'b1, cur_r = 1'b0;

    // Monitor: every cycle with a pending expectation is checked on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (pc_plus !== e.pcp || phase !== e.ph || halted !== e.hl ||
                stack_full !== e.fu || stack_empty !== e.em || stack_err !== e.er) begin
                errors++;
                $display("FAIL vec%0d: got pc_plus=%h phase=%b halted=%b full=%b empty=%b err=%b, want %h %b %b %b %b %b",
                         e.id, pc_plus, phase, halted, stack_full, stack_empty, stack_err,
                         e.pcp, e.ph, e.hl, e.fu, e.em, e.er);
            end
        end
    end

    task automatic push_exp(input int id, input logic [7:0] p, input logic ph, input logic hl);
        exp_t e;
        e.pcp = p; e.ph = ph; e.hl = hl;
        e.fu = cur_f; e.em = cur_e; e.er = cur_r; e.id = id;
        exp_q.push_back(e);
    endtask

    task automatic clear_ctl();
        branch_taken = 1'b0; branch_offset = 8'h00; jump = 1'b0;
        call = 1'b0; ret = 1'b0; jump_target = 8'h00; halt = 1'b0;
    endtask

    // One instruction: FETCH cycle then EXECUTE cycle. Called at posedge+2 in FETCH.
    task automatic instr(input int id, input logic [7:0] p,
                         input logic br, input logic [7:0] off, input logic jm,
                         input logic ca, input logic re, input logic [7:0] tg, input logic hl,
                         input logic [7:0] exp_pc, input logic fa, input logic ea, input logic ra);
        logic [7:0] inc;
        inc = p + 8'd1;
        pc = p; branch_taken = br; branch_offset = off; jump = jm;
        call = ca; ret = re; jump_target = tg; halt = hl;
        push_exp(id, inc, 1'b0, 1'b0);
        @(posedge clk); #2;
        // Conflicting controls during EXECUTE must be ignored.
        branch_taken = ~br; branch_offset = 8'h55; jump = 1'b1;
        call = 1'b1; ret = 1'b1; jump_target = 8'hAA; halt = 1'b1;
        push_exp(id, exp_pc, 1'b1, 1'b0);
        @(posedge clk); #2;
        clear_ctl();
        cur_f = fa; cur_e = ea; cur_r = ra;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, queue=%0d want 0", exp_q.size());
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        reset = 1'b1;
        pc    = 8'h10;
        clear_ctl();
        @(posedge clk); #2;
        push_exp(0, 8'h11, 1'b0, 1'b0);          // held in reset: pc + STEP, FETCH
        @(posedge clk); #2;
        reset = 1'b0;

        //     id  pc     br off    jm ca re tgt    hl exp                      full      empty     err
        instr(1,  8'h10, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h11,                  0,        1,        0);
        instr(2,  8'h11, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h12,                  0,        1,        0);
        instr(3,  8'hFE, 1, 8'h05, 0, 0, 0, 8'h00, 0, 8'h03,                  0,        1,        0);
        instr(4,  8'h02, 1, 8'hFC, 0, 0, 0, 8'h00, 0, 8'hFE,                  0,        1,        0);
        instr(5,  8'h08, 1, 8'h10, 1, 0, 0, 8'h40, 0, 8'h40,                  0,        1,        0);
        instr(6,  8'hFF, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00,                  0,        1,        0);
        instr(7,  8'h20, 0, 8'h00, 0, 1, 0, 8'h80, 0, 8'h80,                  0,        !RS,      0);
        instr(8,  8'h85, 0, 8'h00, 0, 0, 1, 8'h00, 0, RS ? 8'h21 : 8'h86,     0,        1,        0);
        // Fill the 4-deep stack, then overflow on the fifth call.
        instr(9,  8'h30, 0, 8'h00, 0, 1, 0, 8'h60, 0, 8'h60,                  0,        !RS,      0);
        instr(10, 8'h31, 0, 8'h00, 0, 1, 0, 8'h61, 0, 8'h61,                  0,        !RS,      0);
        instr(11, 8'h32, 0, 8'h00, 0, 1, 0, 8'h62, 0, 8'h62,                  0,        !RS,      0);
        instr(12, 8'h33, 0, 8'h00, 0, 1, 0, 8'h63, 0, 8'h63,                  RS,       !RS,      0);
        instr(13, 8'h34, 0, 8'h00, 0, 1, 0, 8'h64, 0, 8'h64,                  RS,       !RS,      RS);
        instr(14, 8'h70, 0, 8'h00, 0, 0, 1, 8'h00, 0, RS ? 8'h34 : 8'h71,     0,        !RS,      RS);
        instr(15, 8'h71, 0, 8'h00, 0, 0, 1, 8'h00, 0, RS ? 8'h33 : 8'h72,     0,        !RS,      RS);

        // Reset during the EXECUTE of a call: push discarded, stack and error cleared.
        pc = 8'h60; call = 1'b1; jump_target = 8'h90;
        push_exp(16, 8'h61, 1'b0, 1'b0);
        @(posedge clk); #2;
        clear_ctl();
        push_exp(16, 8'h90, 1'b1, 1'b0);
        #4;
        reset = 1'b1;
        cur_f = 1'b0; cur_e = 1'b1; cur_r = 1'b0;
        push_exp(17, 8'h61, 1'b0, 1'b0);
        @(posedge clk); #2;
        @(posedge clk); #2;
        reset = 1'b0;

        // Return with an empty stack right after reset.
        instr(18, 8'h70, 0, 8'h00, 0, 0, 1, 8'h00, 0, 8'h71,                  0,        1,        RS);
        // Halt outranks the other captured controls.
        instr(19, 8'h33, 1, 8'h07, 1, 0, 0, 8'h50, 1, 8'h33,                  0,        1,        RS);
        for (int i = 0; i < 4; i++) begin
            pc = 8'h33;
            branch_taken = 1'b1; jump = 1'b1; call = 1'b1; ret = 1'b1;
            jump_target = 8'hC0; halt = 1'b0;
            push_exp(20 + i, 8'h33, 1'b1, 1'b1);
            @(posedge clk); #2;
        end
        clear_ctl();

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations unconsumed, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
